// File: rtl/chrom_eval_pkg.sv
// Shared types and address-map constants for the chromosome evaluation controller.
package chrom_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int SEGMENT_WIDTH = 32;
  localparam int EXPECTED_LSB  = 16;
  localparam int INPUT_LSB     = 0;
  localparam int SEGMENT_BASE  = 0;

  // Vector k lives at vector_base + k, directly after the chromosome words.
  function automatic int vector_base(input int num_segments);
    return SEGMENT_BASE + num_segments;
  endfunction

  function automatic int vector_addr(input int num_segments, input int k);
    return vector_base(num_segments) + k;
  endfunction

endpackage

// File: rtl/chrom_error_counter.sv
// Per-output-bit saturating mismatch accumulators with synchronous clear.
module chrom_error_counter #(
  parameter int OUT_WIDTH = 8,
  parameter int SUM_WIDTH = 32
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic                           iClear,
  input  logic                           iEnable,
  input  logic [OUT_WIDTH-1:0]           iMismatch,
  output logic [OUT_WIDTH*SUM_WIDTH-1:0] oSums
);

  logic [SUM_WIDTH-1:0] r_sum [OUT_WIDTH];

  always_ff @(posedge iClock) begin
    if (iReset || iClear) begin
      for (int b = 0; b < OUT_WIDTH; b++) r_sum[b] <= '0;
    end else if (iEnable) begin
      for (int b = 0; b < OUT_WIDTH; b++) begin
        // Stop at all-ones so long runs never wrap back to a small count.
        if (iMismatch[b] && (r_sum[b] != '1))
          r_sum[b] <= r_sum[b] + SUM_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_out
    assign oSums[g*SUM_WIDTH +: SUM_WIDTH] = r_sum[g];
  end

endmodule

// File: rtl/chrom_eval_controller.sv
// Double-buffered chromosome/vector loader and evaluation sequencer.
// Optional settle stall enabled by defining CHROM_EVAL_STALL_EN.
module chrom_eval_controller
  import chrom_eval_pkg::*;
#(
  parameter int NUM_SEGMENTS  = 31,
  parameter int NUM_VECTORS   = 16,
  parameter int IN_WIDTH      = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int SUM_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 4,
  localparam int AW    = $clog2(NUM_SEGMENTS + NUM_VECTORS),
  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int CW    = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                              iClock,
  input  logic                              iReset,
  input  logic                              iWriteEnable,
  input  logic [AW-1:0]                     iWriteAddress,
  input  logic [31:0]                       iWriteData,
  input  logic                              iStartProcessing,
  input  logic                              iDoneProcessingFeedback,
  input  logic [OUT_WIDTH-1:0]              iCircuitOutput,
`ifdef CHROM_EVAL_STALL_EN
  input  logic                              iStall,
  input  logic [IDX_W-1:0]                  iStallIndex,
`endif
  output logic [SEGMENT_WIDTH*NUM_SEGMENTS-1:0] oChromDescription,
  output logic [IN_WIDTH-1:0]               oCircuitInput,
  output logic                              oReadyToProcess,
  output logic                              oDoneProcessing,
  output logic [OUT_WIDTH*SUM_WIDTH-1:0]    oErrorSums,
  output logic [2:0]                        oState
);

  localparam int VBASE = vector_base(NUM_SEGMENTS);

  logic [SEGMENT_WIDTH-1:0] r_stg_seg [NUM_SEGMENTS];
  logic [IN_WIDTH-1:0]      r_stg_in  [NUM_VECTORS];
  logic [OUT_WIDTH-1:0]     r_stg_exp [NUM_VECTORS];

  logic [SEGMENT_WIDTH*NUM_SEGMENTS-1:0] r_chrom;
  logic [IN_WIDTH-1:0]      r_in  [NUM_VECTORS];
  logic [OUT_WIDTH-1:0]     r_exp [NUM_VECTORS];

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_start_d;
  logic [IDX_W-1:0]     r_idx;
  logic [CW-1:0]        r_cnt;
  logic [IN_WIDTH-1:0]  r_circ_in;

  logic                 w_start_rise;
  logic                 w_accept;
  logic                 w_sample;
  logic                 w_last;
  logic                 w_cnt_done;
  logic                 w_hold;
  logic [OUT_WIDTH-1:0] w_mismatch;

  assign w_start_rise = iStartProcessing && !r_start_d;
  assign w_last       = (int'(r_idx) == NUM_VECTORS - 1);
  assign w_cnt_done   = (int'(r_cnt) == SETTLE_CYCLES - 1);
  assign w_mismatch   = iCircuitOutput ^ r_exp[r_idx];

`ifdef CHROM_EVAL_STALL_EN
  assign w_hold = iStall && (r_idx == iStallIndex);
`else
  assign w_hold = 1'b0;
`endif

  // Staging accepts writes in every state; runs only see it on start.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int s = 0; s < NUM_SEGMENTS; s++) r_stg_seg[s] <= '0;
      for (int k = 0; k < NUM_VECTORS; k++) begin
        r_stg_in[k]  <= '0;
        r_stg_exp[k] <= '0;
      end
    end else if (iWriteEnable) begin
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        if (int'(iWriteAddress) == SEGMENT_BASE + s)
          r_stg_seg[s] <= iWriteData;
      end
      for (int k = 0; k < NUM_VECTORS; k++) begin
        if (int'(iWriteAddress) == VBASE + k) begin
          r_stg_in[k]  <= iWriteData[INPUT_LSB +: IN_WIDTH];
          r_stg_exp[k] <= iWriteData[EXPECTED_LSB +: OUT_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_chrom <= '0;
      for (int k = 0; k < NUM_VECTORS; k++) begin
        r_in[k]  <= '0;
        r_exp[k] <= '0;
      end
    end else if (w_accept) begin
      for (int s = 0; s < NUM_SEGMENTS; s++)
        r_chrom[s*SEGMENT_WIDTH +: SEGMENT_WIDTH] <= r_stg_seg[s];
      for (int k = 0; k < NUM_VECTORS; k++) begin
        r_in[k]  <= r_stg_in[k];
        r_exp[k] <= r_stg_exp[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_hold && w_cnt_done) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        if (iDoneProcessingFeedback) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_start_d <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_circ_in <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      // Tracks start in every state so a held level never re-arms.
      r_start_d <= iStartProcessing;
      if (w_accept)
        r_idx <= '0;
      else if (w_sample && !w_last)
        r_idx <= r_idx + IDX_W'(1);
      if (r_state == ST_APPLY) begin
        r_circ_in <= r_in[r_idx];
        r_cnt     <= '0;
      end else if (r_state == ST_SETTLE && !w_hold && !w_cnt_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  chrom_error_counter #(
    .OUT_WIDTH (OUT_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_err (
    .iClock    (iClock),
    .iReset    (iReset),
    .iClear    (w_accept),
    .iEnable   (w_sample),
    .iMismatch (w_mismatch),
    .oSums     (oErrorSums)
  );

  assign oChromDescription = r_chrom;
  assign oCircuitInput     = r_circ_in;
  assign oReadyToProcess   = r_ready;
  assign oDoneProcessing   = r_done;
  assign oState            = r_state;

endmodule
